// File: rtl/unary_pkg.sv
// Shared types and constants for the unary rate-coded multiplier path.
// The default LOG_LEN also sizes the Sobol comparators on the encoder side.
package unary_pkg;

  localparam int unsigned DefaultWidth  = 16;
  localparam int unsigned DefaultLogLen = DefaultWidth - 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/unary_bit_counter.sv
// Ones and sample-period accumulators for one unary decode window, with a flag
// that marks the sample which completes the full 2^LogLen window.
module unary_bit_counter
  import unary_pkg::*;
#(
  parameter int unsigned LogLen = DefaultLogLen
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic            bit_i,
  output logic [LogLen:0] ones_next_o,
  output logic [LogLen:0] cyc_next_o,
  output logic            last_o
);

  localparam logic [LogLen:0] FullLen = {1'b1, {LogLen{1'b0}}};
  localparam logic [LogLen:0] LastCyc = FullLen - 1'b1;

  logic [LogLen:0] ones_q, ones_d;
  logic [LogLen:0] cyc_q, cyc_d;

  // Post-sample values are exposed so the owner can capture the final sample
  // on the same edge that ends the window.
  assign ones_next_o = ones_q + {{LogLen{1'b0}}, bit_i};
  assign cyc_next_o  = cyc_q + 1'b1;
  assign last_o      = (cyc_q == LastCyc);

  always_comb begin
    ones_d = ones_q;
    cyc_d  = cyc_q;
    if (clr_i) begin
      ones_d = '0;
      cyc_d  = '0;
    end else if (en_i) begin
      ones_d = ones_next_o;
      cyc_d  = cyc_next_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_q <= '0;
      cyc_q  <= '0;
    end else begin
      ones_q <= ones_d;
      cyc_q  <= cyc_d;
    end
  end

endmodule

// File: rtl/unary_rate_decoder.sv
// Counts ones in a unary product bitstream over a 2^LOG_LEN window (or until an
// early stop) and hands the count and sampled-period count out over valid/ready.
module unary_rate_decoder
  import unary_pkg::*;
#(
  parameter int unsigned WIDTH   = DefaultWidth,
  parameter int unsigned LOG_LEN = WIDTH - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_bit,
  input  logic             i_stop,
  output logic             o_run,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [LOG_LEN:0] o_count,
  output logic [LOG_LEN:0] o_cycles
);

  state_e state_q, state_d;

  logic             acc_clr;
  logic             acc_en;
  logic             acc_last;
  logic             done_entry;
  logic [LOG_LEN:0] ones_next;
  logic [LOG_LEN:0] cyc_next;
  logic [LOG_LEN:0] count_q, count_d;
  logic [LOG_LEN:0] cycles_q, cycles_d;

  unary_bit_counter #(
    .LogLen(LOG_LEN)
  ) u_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (acc_clr),
    .en_i       (acc_en),
    .bit_i      (i_bit),
    .ones_next_o(ones_next),
    .cyc_next_o (cyc_next),
    .last_o     (acc_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (i_start) state_d = StRun;
      StRun:  if (i_stop || acc_last) state_d = StDone;
      StDone: if (i_ready) state_d = i_start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_run      = (state_q == StRun);
    o_valid    = (state_q == StDone);
    acc_en     = (state_q == StRun);
    // A window starts from IDLE or back-to-back from a completing handshake.
    acc_clr    = i_start && ((state_q == StIdle) || ((state_q == StDone) && i_ready));
    done_entry = (state_q == StRun) && (i_stop || acc_last);
  end

  always_comb begin
    count_d  = count_q;
    cycles_d = cycles_q;
    if (done_entry) begin
      count_d  = ones_next;
      cycles_d = cyc_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      cycles_q <= '0;
    end else begin
      count_q  <= count_d;
      cycles_q <= cycles_d;
    end
  end

  assign o_count  = count_q;
  assign o_cycles = cycles_q;

endmodule

// File: tb/tb_unary_rate_decoder.sv
// Directed vector bench for unary_rate_decoder at LOG_LEN=4 plus a long-window
// instance at LOG_LEN=15 driven with a 0.25-density product stream.
module tb_unary_rate_decoder;

  localparam int LL  = 4;
  localparam int N   = 16;
  localparam int LL2 = 15;

  logic          clk;
  logic          rst_n;
  logic          i_start, i_bit, i_stop, i_ready;
  logic          o_run, o_valid;
  logic [LL:0]   o_count, o_cycles;

  logic          i_start2, i_bit2, i_stop2, i_ready2;
  logic          o_run2, o_valid2;
  logic [LL2:0]  o_count2, o_cycles2;

  int checks;
  int errors;

  typedef struct {
    logic [15:0] bits;
    int          stop_at;
    int          exp_count;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[7];

  unary_rate_decoder #(
    .WIDTH  (5),
    .LOG_LEN(LL)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (i_start),
    .i_bit   (i_bit),
    .i_stop  (i_stop),
    .o_run   (o_run),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_count (o_count),
    .o_cycles(o_cycles)
  );

  unary_rate_decoder #(
    .WIDTH  (16),
    .LOG_LEN(LL2)
  ) dut2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (i_start2),
    .i_bit   (i_bit2),
    .i_stop  (i_stop2),
    .o_run   (o_run2),
    .o_valid (o_valid2),
    .i_ready (i_ready2),
    .o_count (o_count2),
    .o_cycles(o_cycles2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Start a window, feed bits[k] on RUN cycle k+1, stop on RUN cycle stop_at
  // (0 = never). Leaves the DUT in DONE; checks latency and results.
  task automatic do_window(input logic [15:0] bits, input int stop_at,
                           input int exp_cnt, input int exp_cyc, input string name);
    int n;
    logic [15:0] b;
    b = bits;
    n = 0;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    check({name, "_run_after_start"}, int'(o_run), 1);
    while (!o_valid && n < 40) begin
      i_bit  = (n < 16) ? b[n] : 1'b0;
      i_stop = (n + 1 == stop_at);
      n++;
      step();
    end
    i_bit  = 1'b0;
    i_stop = 1'b0;
    check({name, "_run_cycles"}, n, exp_cyc);
    check({name, "_run_low"}, int'(o_run), 0);
    check({name, "_count"}, int'(o_count), exp_cnt);
    check({name, "_cycles"}, int'(o_cycles), exp_cyc);
  endtask

  task automatic accept(input int exp_cnt, input string name);
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    check({name, "_valid_dropped"}, int'(o_valid), 0);
    check({name, "_count_retained"}, int'(o_count), exp_cnt);
  endtask

  initial begin
    int n;
    int diff;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    {i_start, i_bit, i_stop, i_ready} = '0;
    {i_start2, i_bit2, i_stop2, i_ready2} = '0;

    vecs[0] = '{16'hFFFF, 0, 16, 16};  // all ones, full window
    vecs[1] = '{16'h5555, 0, 8, 16};   // 1010... starting with 1
    vecs[2] = '{16'hFFFF, 6, 6, 6};    // early stop on 6th RUN cycle
    vecs[3] = '{16'hFFFF, 16, 16, 16}; // stop coincides with final sample
    vecs[4] = '{16'hFFFF, 1, 1, 1};    // stop on first RUN cycle
    vecs[5] = '{16'h0000, 0, 0, 16};   // all zeros
    vecs[6] = '{16'h00FF, 10, 8, 10};  // ones then zeros, stop at 10

    #12;
    check("reset_run", int'(o_run), 0);
    check("reset_valid", int'(o_valid), 0);
    check("reset_count", int'(o_count), 0);
    check("reset_cycles", int'(o_cycles), 0);
    rst_n = 1'b1;
    step();

    // i_stop outside RUN is ignored in IDLE
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    check("idle_stop_run", int'(o_run), 0);
    check("idle_stop_valid", int'(o_valid), 0);

    for (int v = 0; v < 7; v++) begin
      do_window(vecs[v].bits, vecs[v].stop_at, vecs[v].exp_count, vecs[v].exp_cycles,
                $sformatf("vec%0d", v));
      accept(vecs[v].exp_count, $sformatf("vec%0d", v));
    end

    // Hold ready low 5 cycles with i_stop and i_start noise: outputs must hold.
    do_window(16'h5555, 0, 8, 16, "hold");
    for (int k = 0; k < 5; k++) begin
      i_stop  = (k == 1);
      i_start = (k == 3);
      step();
      check("hold_valid", int'(o_valid), 1);
      check("hold_run", int'(o_run), 0);
      check("hold_count", int'(o_count), 8);
      check("hold_cycles", int'(o_cycles), 16);
    end
    i_stop  = 1'b0;
    i_start = 1'b0;
    accept(8, "hold");
    check("hold_idle_run", int'(o_run), 0);

    // Back-to-back: handshake with start, second window of zeros, start in RUN ignored.
    do_window(16'hFFFF, 0, 16, 16, "b2b_first");
    i_ready = 1'b1;
    i_start = 1'b1;
    step();
    i_ready = 1'b0;
    i_start = 1'b0;
    check("b2b_run", int'(o_run), 1);
    check("b2b_valid", int'(o_valid), 0);
    n = 0;
    while (!o_valid && n < 40) begin
      i_bit   = 1'b0;
      i_start = (n == 2) || (n == 9);
      n++;
      step();
    end
    i_start = 1'b0;
    check("b2b_run_cycles", n, 16);
    check("b2b_count", int'(o_count), 0);
    check("b2b_cycles", int'(o_cycles), 16);
    accept(0, "b2b");

    // Prime a nonzero result, then reset mid-RUN.
    do_window(16'h00FF, 0, 8, 16, "pre_rst");
    accept(8, "pre_rst");
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    i_bit = 1'b1;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check("rst_run_run", int'(o_run), 0);
    check("rst_run_valid", int'(o_valid), 0);
    check("rst_run_count", int'(o_count), 0);
    check("rst_run_cycles", int'(o_cycles), 0);
    #1 rst_n = 1'b1;
    i_bit = 1'b0;
    step();
    do_window(16'hFFFF, 0, 16, 16, "after_rst");

    // Reset mid-DONE drops valid asynchronously.
    #2 rst_n = 1'b0;
    #1;
    check("rst_done_valid", int'(o_valid), 0);
    check("rst_done_count", int'(o_count), 0);
    #1 rst_n = 1'b1;
    step();

    // Long window: product of two 0.5-density streams (c[0] & c[1]), 2^15 samples.
    i_start2 = 1'b1;
    step();
    i_start2 = 1'b0;
    n = 0;
    while (!o_valid2 && n < 40000) begin
      i_bit2 = n[0] & n[1];
      n++;
      step();
    end
    i_bit2 = 1'b0;
    check("e2e_run_cycles", n, 32768);
    check("e2e_cycles", int'(o_cycles2), 32768);
    diff = int'(o_count2) - 8192;
    if (diff < 0) diff = -diff;
    check("e2e_count_within_1", int'(diff <= 1), 1);
    i_ready2 = 1'b1;
    step();
    i_ready2 = 1'b0;
    check("e2e_valid_dropped", int'(o_valid2), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
